// File: rtl/port_alloc_seq_if.sv
// +------------------------------------------------------------------+
// | port_alloc_seq_if : batch handshake and result bus for           |
// |                     port_alloc_seq                               |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

interface port_alloc_seq_if #(
  parameter int NUM_PORT = 5,
  parameter int NUM_FLIT = 4,
  parameter int CNT_W    = 16
);
  logic                         start;
  logic [NUM_FLIT*NUM_PORT-1:0] req_in;
  logic [NUM_FLIT-1:0]          valid_in;
  logic [NUM_PORT-1:0]          avail_in;
  logic                         busy;
  logic                         done;
  logic [NUM_FLIT*NUM_PORT-1:0] alloc_out;
  logic [NUM_FLIT-1:0]          deflected_out;
  logic [NUM_PORT-1:0]          remain_out;
  logic [CNT_W-1:0]             defl_cnt;

  modport master (
    output start, req_in, valid_in, avail_in,
    input  busy, done, alloc_out, deflected_out, remain_out, defl_cnt
  );

  modport slave (
    input  start, req_in, valid_in, avail_in,
    output busy, done, alloc_out, deflected_out, remain_out, defl_cnt
  );
endinterface

`default_nettype wire

// File: rtl/port_alloc_seq.sv
// +------------------------------------------------------------------+
// | port_alloc_seq : serial one-flit-per-cycle port allocator with   |
// |                  round-robin deflection and deflection counter   |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
`default_nettype none

module port_alloc_seq #(
  parameter int NUM_PORT = 5,
  parameter int NUM_FLIT = 4,
  parameter int CNT_W    = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  port_alloc_seq_if.slave   bus
);

  localparam int PW = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
  localparam int FW = (NUM_FLIT > 1) ? $clog2(NUM_FLIT) : 1;

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_alloc = 2'd1;
  localparam logic [1:0] c_st_done  = 2'd2;

  localparam logic [PW:0]   c_num_port  = (PW+1)'(NUM_PORT);
  localparam logic [PW-1:0] c_last_port = PW'(NUM_PORT - 1);
  localparam logic [FW-1:0] c_last_idx  = FW'(NUM_FLIT - 1);

  logic [1:0]                   state_q,  state_d;
  logic [FW-1:0]                idx_q,    idx_d;
  logic [PW-1:0]                rr_ptr_q, rr_ptr_d;
  logic [NUM_FLIT*NUM_PORT-1:0] req_q,    req_d;
  logic [NUM_FLIT-1:0]          valid_q,  valid_d;
  logic [NUM_PORT-1:0]          avail_q,  avail_d;
  logic [NUM_FLIT*NUM_PORT-1:0] alloc_q,  alloc_d;
  logic [NUM_FLIT-1:0]          defl_q,   defl_d;
  logic [NUM_PORT-1:0]          remain_q, remain_d;
  logic [CNT_W-1:0]             cnt_q,    cnt_d;
  logic                         done_q,   done_d;

  logic [NUM_PORT-1:0] cur_req;
  logic                cur_valid;
  logic [NUM_PORT-1:0] prod_mask;
  logic [NUM_PORT-1:0] prod_grant;
  logic [PW:0]         rr_pos;
  logic [PW-1:0]       rr_idx;
  logic                rr_found;
  logic [NUM_PORT-1:0] rr_grant;
  logic [NUM_PORT-1:0] grant;
  logic                grant_defl;

  // Slot of the flit being allocated this cycle
  always_comb begin
    cur_req   = '0;
    cur_valid = 1'b0;
    for (int f = 0; f < NUM_FLIT; f++) begin
      if (idx_q == FW'(f)) begin
        cur_req   = req_q[f*NUM_PORT +: NUM_PORT];
        cur_valid = valid_q[f];
      end
    end
  end

  // Productive choice: highest requested port that is still free
  always_comb begin
    prod_mask  = cur_req & avail_q;
    prod_grant = '0;
    for (int p = 0; p < NUM_PORT; p++) begin
      if (prod_mask[p]) begin
        prod_grant    = '0;
        prod_grant[p] = 1'b1;
      end
    end
  end

  // Deflection choice: first free port at or above rr_ptr, wrapping
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_pos   = '0;
    for (int k = 0; k < NUM_PORT; k++) begin
      rr_pos = {1'b0, rr_ptr_q} + (PW+1)'(k);
      if (rr_pos >= c_num_port) begin
        rr_pos = rr_pos - c_num_port;
      end
      if (!rr_found && avail_q[rr_pos[PW-1:0]]) begin
        rr_found = 1'b1;
        rr_idx   = rr_pos[PW-1:0];
      end
    end
    rr_grant = '0;
    if (rr_found) begin
      rr_grant[rr_idx] = 1'b1;
    end
  end

  always_comb begin
    grant      = '0;
    grant_defl = 1'b0;
    if (cur_valid) begin
      if (|prod_mask) begin
        grant = prod_grant;
      end else if (|avail_q) begin
        grant      = rr_grant;
        grant_defl = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    rr_ptr_d = rr_ptr_q;
    req_d    = req_q;
    valid_d  = valid_q;
    avail_d  = avail_q;
    alloc_d  = alloc_q;
    defl_d   = defl_q;
    remain_d = remain_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    case (state_q)
      c_st_idle: begin
        if (bus.start) begin
          req_d   = bus.req_in;
          valid_d = bus.valid_in;
          avail_d = bus.avail_in;
          alloc_d = '0;
          defl_d  = '0;
          idx_d   = '0;
          state_d = c_st_alloc;
        end
      end

      c_st_alloc: begin
        for (int f = 0; f < NUM_FLIT; f++) begin
          if (idx_q == FW'(f)) begin
            alloc_d[f*NUM_PORT +: NUM_PORT] = grant;
            defl_d[f]                       = grant_defl;
          end
        end
        avail_d = avail_q & ~grant;
        if (grant_defl) begin
          rr_ptr_d = (rr_idx == c_last_port) ? '0 : rr_idx + 1'b1;
          if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        if (idx_q == c_last_idx) begin
          state_d = c_st_done;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      c_st_done: begin
        done_d   = 1'b1;
        remain_d = avail_q;
        state_d  = c_st_idle;
      end

      default: begin
        state_d = c_st_idle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= c_st_idle;
      idx_q    <= '0;
      rr_ptr_q <= '0;
      req_q    <= '0;
      valid_q  <= '0;
      avail_q  <= '0;
      alloc_q  <= '0;
      defl_q   <= '0;
      remain_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      rr_ptr_q <= rr_ptr_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      avail_q  <= avail_d;
      alloc_q  <= alloc_d;
      defl_q   <= defl_d;
      remain_q <= remain_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy          = (state_q == c_st_alloc) || (state_q == c_st_done);
  assign bus.done          = done_q;
  assign bus.alloc_out     = alloc_q;
  assign bus.deflected_out = defl_q;
  assign bus.remain_out    = remain_q;
  assign bus.defl_cnt      = cnt_q;

endmodule

`default_nettype wire
